// File: rtl/hog_gradient.sv
// Centred-difference gradient stage for the HOG pipeline: gx, gy and gx^2+gy^2.
// Optional frame-end marker output grad_eof is enabled by defining HOG_GRAD_EOF_EN.
module hog_gradient #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid,
    input  logic [PIX_W-1:0]   pix_data,
    output logic               grad_valid,
    output logic [PIX_W:0]     gx,
    output logic [PIX_W:0]     gy,
`ifdef HOG_GRAD_EOF_EN
    output logic               grad_eof,
`endif
    output logic [2*PIX_W:0]   mag_sq
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    logic [PIX_W-1:0] r_lb1 [IMG_W];
    logic [PIX_W-1:0] r_lb2 [IMG_W];

    logic [2:0][PIX_W-1:0] r_top;
    logic [2:0][PIX_W-1:0] r_mid;
    logic [2:0][PIX_W-1:0] r_bot;

    logic r_v1;
    logic r_v2;
    logic r_v3;

    logic [PIX_W:0]   r_gx2;
    logic [PIX_W:0]   r_gy2;
    logic [PIX_W:0]   r_gx3;
    logic [PIX_W:0]   r_gy3;
    logic [2*PIX_W:0] r_mag3;

    logic               w_emit;
    logic [PIX_W-1:0]   w_top_n;
    logic [PIX_W-1:0]   w_mid_n;
    logic [PIX_W:0]     w_gx;
    logic [PIX_W:0]     w_gy;
    logic [PIX_W:0]     w_ngx;
    logic [PIX_W:0]     w_ngy;
    logic [PIX_W-1:0]   w_ax;
    logic [PIX_W-1:0]   w_ay;
    logic [2*PIX_W-1:0] w_sqx;
    logic [2*PIX_W-1:0] w_sqy;
    logic [2*PIX_W:0]   w_sum;

    // Only pixels from row 2 / col 2 onward complete a full 3x3 window
    assign w_emit  = pix_valid && (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_top_n = r_lb2[r_col];
    assign w_mid_n = r_lb1[r_col];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (pix_valid) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pix_valid) begin
            r_lb2[r_col] <= w_mid_n;
            r_lb1[r_col] <= pix_data;
            r_top        <= {w_top_n, r_top[2:1]};
            r_mid        <= {w_mid_n, r_mid[2:1]};
            r_bot        <= {pix_data, r_bot[2:1]};
        end
    end

    // Zero-extended operands: the PIX_W+1 bit difference cannot overflow
    assign w_gx = {1'b0, r_mid[2]} - {1'b0, r_mid[0]};
    assign w_gy = {1'b0, r_bot[1]} - {1'b0, r_top[1]};

    always_ff @(posedge clk) begin
        if (r_v1) begin
            r_gx2 <= w_gx;
            r_gy2 <= w_gy;
        end
    end

    assign w_ngx = -r_gx2;
    assign w_ngy = -r_gy2;
    assign w_ax  = r_gx2[PIX_W] ? w_ngx[PIX_W-1:0] : r_gx2[PIX_W-1:0];
    assign w_ay  = r_gy2[PIX_W] ? w_ngy[PIX_W-1:0] : r_gy2[PIX_W-1:0];
    assign w_sqx = (2*PIX_W)'(w_ax) * (2*PIX_W)'(w_ax);
    assign w_sqy = (2*PIX_W)'(w_ay) * (2*PIX_W)'(w_ay);
    assign w_sum = (2*PIX_W+1)'(w_sqx) + (2*PIX_W+1)'(w_sqy);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_gx3  <= '0;
            r_gy3  <= '0;
            r_mag3 <= '0;
        end else begin
            r_v1 <= w_emit;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            if (r_v2) begin
                r_gx3  <= r_gx2;
                r_gy3  <= r_gy2;
                r_mag3 <= w_sum;
            end
        end
    end

    assign grad_valid = r_v3;
    assign gx         = r_gx3;
    assign gy         = r_gy3;
    assign mag_sq     = r_mag3;

`ifdef HOG_GRAD_EOF_EN
    logic w_last;
    logic r_e1;
    logic r_e2;
    logic r_e3;

    // Last pixel of the frame generates the last interior centre
    assign w_last = pix_valid && (r_row == ROW_LAST) && (r_col == COL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_e1 <= 1'b0;
            r_e2 <= 1'b0;
            r_e3 <= 1'b0;
        end else begin
            r_e1 <= w_last;
            r_e2 <= r_e1;
            r_e3 <= r_e2;
        end
    end

    assign grad_eof = r_e3;
`endif

endmodule

// File: doc/hog_gradient.md
# hog_gradient

Computes per-pixel centred-difference gradients for the HOG pipeline. It consumes a raster-ordered grayscale pixel stream and keeps the two previous rows in internal line buffers. For every interior pixel it emits signed gx and gy, plus the squared magnitude gx²+gy². It sits directly upstream of the square-root stage: `mag_sq` feeds the root's 17-bit input, and gx/gy go on to orientation binning.

## Interface
Parameters:
- `PIX_W`, 8: pixel width, unsigned.
- `IMG_W`, 640: pixels per row (≥3).
- `IMG_H`, 480: rows per frame (≥3).

Ports:
- `clk`, in, 1: sole clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `pix_valid`, in, 1: `pix_data` is valid this cycle.
- `pix_data`, in, PIX_W: pixel in raster order, row-major, top-left first.
- `grad_valid`, out, 1: gradient outputs are valid this cycle.
- `gx`, out, PIX_W+1: signed two's complement, p(x+1,y) − p(x−1,y).
- `gy`, out, PIX_W+1: signed, p(x,y+1) − p(x,y−1).
- `mag_sq`, out, 2·PIX_W+1: unsigned gx²+gy². Maximum is 130050 at PIX_W=8.
- `grad_eof`, out, 1: present only with `HOG_GRAD_EOF_EN` (see Configuration).

## Operation
- **Position counters:**
  - `col` runs 0..IMG_W−1 and `row` runs 0..IMG_H−1. Both advance only on `pix_valid`.
  - `col` wraps to 0 and increments `row`.
  - After (IMG_W−1, IMG_H−1) both wrap to 0, and the next frame follows with no gap.
- **Line buffers:**
  - Two buffers, each IMG_W×PIX_W, hold rows r−1 and r−2.
  - On each accepted pixel, the column entry shifts down one row, and the new pixel enters row r.
  - A 3×3 window register shifts one column on `pix_valid` only.
- **Which pixels produce output:**
  - A pixel accepted at (r, c) with r ≥ 2 and c ≥ 2 produces the gradient of centre (r−1, c−1).
  - All other positions produce no output. Border centres (row 0, row IMG_H−1, col 0, col IMG_W−1) are never emitted.
  - Exactly (IMG_W−2)·(IMG_H−2) outputs per frame, in raster order of centre.
- **Arithmetic:**
  - Differences are computed at PIX_W+1 bits, sign-extended from zero-extended pixels, so overflow is impossible.
  - Squares are computed at 2·PIX_W bits unsigned, and their sum at 2·PIX_W+1 bits, exact.
- **Flow control:**
  - There is no backpressure; the downstream stage must accept every `grad_valid` cycle.
  - Input gaps (`pix_valid`=0) produce matching output gaps and never corrupt the window.
- **Reset:**
  - Counters go to 0, all pipeline valid bits are cleared, and all outputs go to 0.
  - Line-buffer contents are not cleared. This is safe because rows 0–1 never produce output.
  - Reset mid-frame discards the partial frame; the next accepted pixel is (0,0).

## Timing
- Three-stage pipeline:
  - S1: window/line-buffer update.
  - S2: gx and gy registered.
  - S3: squares summed and `mag_sq` registered.
- `grad_valid`/`gx`/`gy`/`mag_sq` assert exactly 3 cycles after the `pix_valid` cycle of the generating pixel. `gx`/`gy` are delayed to stay aligned with `mag_sq`.
- Fixed latency independent of input gaps. Throughput is one output per cycle sustained.
- Outputs hold their last value while `grad_valid`=0. Consumers must qualify on `grad_valid`.
- A `rst` cycle clears in-flight valid bits: no `grad_valid` in the 3 cycles after reset, even for pixels accepted just before it.

## Configuration
- Macro: `HOG_GRAD_EOF_EN`.
- **Defined:**
  - Adds output `grad_eof` (1 bit, reset 0).
  - It pulses high with `grad_valid` on the frame's last output, centre (IMG_H−2, IMG_W−2), and is 0 otherwise.
- **Undefined:** the port and its logic are absent, and all other behaviour is identical.

## Test plan
(IMG_W=8, IMG_H=6, PIX_W=8 unless stated.)
- **Flat frame:** constant frame, all pixels 100 → exactly 24 outputs, all gx=gy=0 and mag_sq=0.
- **Horizontal ramp:** pix=10·col → every output gx=20, gy=0, mag_sq=400.
- **Vertical step:** rows 0–2 = 0, rows 3–5 = 255 → centre rows 2 and 3 give gy=255, gx=0, mag_sq=65025; centre rows 1 and 4 give all zero.
- **Maximum magnitude:** pix=255 when col+row ≥ 6, else 0 → centres with col+row ∈ {5,6} give gx=gy=255, mag_sq=130050. Other centres compare bit-exactly to the golden model.
- **Input gaps:** random `pix_valid` with 40% idle over two back-to-back random frames → outputs bit-exact to the golden model, each exactly 3 cycles after its generating input, 24 per frame.
- **Reset mid-frame:** assert `rst` after pixel (3,4), then send a full random frame → nothing emitted in the 3 cycles after `rst` and none before pixel (2,2) of the new frame; results match the golden model. With `HOG_GRAD_EOF_EN`, `grad_eof` fires once, on centre (4,6).
